tmult_axis: RTL
===============

TMULT_AXIS -- requirements
Module: tmult_axis

Interface
REQ-001 EXP, default 5: exponent field width.
REQ-002 FRA, default 10: stored fraction field width; word width W = EXP+FRA+1.
REQ-003 aclk  input  1  sole clock, all state on rising edge.
REQ-004 aresetn  input  1  reset, asynchronous and active-low.
REQ-005 s_axis_a_tdata  input  W  operand A {sign, exponent, fraction}.
REQ-006 s_axis_a_tvalid  input  1 / s_axis_a_tready  output  1  operand A handshake.
REQ-007 s_axis_b_tdata  input  W / s_axis_b_tvalid  input  1 / s_axis_b_tready  output  1  operand B, same layout.
REQ-008 rnd_mode  input  1  rounding mode: 0 = round-nearest-even (RNE), 1 = round-toward-zero (RTZ); sampled with the operands.
REQ-009 m_axis_result_tdata  output  W  packed product.
REQ-010 m_axis_result_tvalid  output  1 / m_axis_result_tready  input  1  result handshake with real backpressure.
REQ-011 flag  output  5  result-aligned status: [0] zero, [1] inf, [2] NaN, [3] overflow, [4] inexact.

Function
REQ-012 An operand pair SHALL be accepted only on a cycle where both tvalids and the shared tready are high; a single operand is never consumed alone.
REQ-013 s_axis_a_tready and s_axis_b_tready SHALL be identical, high exactly when stage 1 is empty or advances this cycle.
REQ-014 Pipeline SHALL be 3 register stages: S1 unpack/classify/sign XOR/biased exponent sum/(FRA+1)x(FRA+1) product; S2 normalize, including leading-zero shift for subnormal operands and sticky right-shift for tiny results; S3 round, renormalize on rounding carry, pack, flags.
REQ-015 Latency SHALL be 3 cycles from accept to m_axis_result_tvalid with tready held high; throughput one pair per cycle.
REQ-016 Each stage SHALL advance when its successor is empty or advancing; bubbles collapse; results leave in acceptance order with no loss or duplication.
REQ-017 While tvalid high and tready low, tdata, flag and tvalid SHALL hold stable.
REQ-018 Subnormal inputs SHALL use hidden bit 0 and exponent 1; results below the normal range SHALL be emitted as subnormals or zero, never flushed.
REQ-019 RNE: ties to even using guard and sticky; RTZ: truncate.
REQ-020 Overflow SHALL produce inf under RNE and max finite (exp 2^EXP-2, fraction all ones) under RTZ, with flag[3] and flag[4] set.
REQ-021 Any NaN input, or inf x 0, SHALL produce canonical quiet NaN (sign 0, exponent all ones, fraction MSB 1, rest 0), flag[2] only.
REQ-022 inf x nonzero finite SHALL give inf with XOR sign, flag[1]; 0 x finite SHALL give signed zero, flag[0].
REQ-023 flag[4] SHALL be set whenever discarded bits are nonzero; flag[0] also for underflow-to-zero.

Reset
REQ-024 While aresetn low: all stage valids, m_axis_result_tvalid, both s tready, tdata and flag SHALL be 0.
REQ-025 Reset mid-operation SHALL discard all in-flight pairs; after release tready rises the first cycle and no result appears before a new accept plus 3 cycles.

Structure
REQ-026 Flag bit indices, rnd_mode encodings and canonical-NaN/max-finite constants SHALL live in shared package tmult_pkg, reused by other fp blocks.
REQ-027 One sub-module, fp_lzc (parametrised leading-zero counter on the FRA+1 significand), SHALL be instantiated in S1/S2; all else inline.

Verification (EXP=5, FRA=10)
REQ-028 0x3C00 x 0x4000, RNE, tready=1 -> 0x4000, flag 0, tvalid exactly 3 cycles after accept; 0x3E00 x 0x3E00 -> 0x4080.
REQ-029 0x7BFF x 0x4000 -> RNE 0x7C00 flag 0b11010; RTZ 0x7BFF flag 0b11000.
REQ-030 0x7C00 x 0x0000 -> 0x7E00 flag 0b00100; 0x8000 x 0x3C00 -> 0x8000 flag 0b00001; 0xFE00 x 0x3C00 -> 0x7E00.
REQ-031 0x0200 x 0x3800 -> 0x0100 flag 0; 0x0001 x 0x3800 RNE -> 0x0000 flag 0b10001; 0x0003 x 0x3800 RNE -> 0x0002 flag 0b10000.
REQ-032 8 back-to-back pairs with m_axis_result_tready toggling 1,0,1,0... -> 8 correct in-order results, outputs stable across stalls, s tready low only when S1 full and blocked.
REQ-033 aresetn pulsed low with 3 pairs in flight -> tvalid 0 immediately, zero results after release until new input.

Source files
------------

// File: rtl/tmult_pkg.sv
// Shared floating-point definitions: flag bit positions, rounding-mode encodings,
// operand classes and canonical special-value encodings.
package tmult_pkg;

  localparam int FLAG_W       = 5;
  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_INF     = 1;
  localparam int FLAG_NAN     = 2;
  localparam int FLAG_OVF     = 3;
  localparam int FLAG_INEXACT = 4;

  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

  typedef enum logic [1:0] {
    CLS_FIN,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  // Quiet NaN with sign 0: exponent all ones, fraction MSB set.
  function automatic logic [63:0] qnan_word(input int exp_w, input int fra_w);
    return (((64'd1 << exp_w) - 64'd1) << fra_w) | (64'd1 << (fra_w - 1));
  endfunction

  // Largest finite magnitude without sign bit.
  function automatic logic [63:0] max_finite_word(input int exp_w, input int fra_w);
    return (((64'd1 << exp_w) - 64'd2) << fra_w) | ((64'd1 << fra_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0]         value,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int CW = $clog2(WIDTH + 1);

  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/tmult_axis.sv
// Three-stage pipelined floating-point multiplier with AXI-Stream operand and result ports.
// S1 unpack/multiply, S2 normalize/denormalize, S3 round/pack/flags.
module tmult_axis
  import tmult_pkg::*;
#(
  parameter int EXP = 5,
  parameter int FRA = 10
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [EXP+FRA:0]  s_axis_a_tdata,
  input  logic              s_axis_a_tvalid,
  output logic              s_axis_a_tready,
  input  logic [EXP+FRA:0]  s_axis_b_tdata,
  input  logic              s_axis_b_tvalid,
  output logic              s_axis_b_tready,
  input  logic              rnd_mode,
  output logic [EXP+FRA:0]  m_axis_result_tdata,
  output logic              m_axis_result_tvalid,
  input  logic              m_axis_result_tready,
  output logic [FLAG_W-1:0] flag
);

  localparam int W    = EXP + FRA + 1;
  localparam int MW   = FRA + 1;
  localparam int PW   = 2 * MW;
  localparam int LW   = $clog2(MW + 1);
  localparam int EW   = EXP + $clog2(PW) + 3;
  localparam int BIAS = (1 << (EXP - 1)) - 1;
  localparam int EMAX = (1 << EXP) - 1;

  localparam logic [63:0]  QNAN_64 = qnan_word(EXP, FRA);
  localparam logic [63:0]  MAXF_64 = max_finite_word(EXP, FRA);
  localparam logic [W-1:0] QNAN    = QNAN_64[W-1:0];
  localparam logic [W-2:0] MAXF    = MAXF_64[W-2:0];

  logic en1, en2, en3, s_ready, accept;
  logic v1, v2, v3;

  assign en3     = ~v3 | m_axis_result_tready;
  assign en2     = ~v2 | en3;
  assign en1     = ~v1 | en2;
  assign s_ready = en1 & aresetn;
  assign accept  = s_axis_a_tvalid & s_axis_b_tvalid & s_ready;

  assign s_axis_a_tready      = s_ready;
  assign s_axis_b_tready      = s_ready;
  assign m_axis_result_tvalid = v3;

  // ---------------- S1: unpack, classify, multiply ----------------
  logic           sa, sb;
  logic [EXP-1:0] ea, eb;
  logic [FRA-1:0] fa, fb;
  logic [MW-1:0]  ma, mb;
  logic [LW-1:0]  lza, lzb;
  logic           a_sub, b_sub, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [EW-1:0]  exp_sum_c;
  fp_class_e      cls_c;

  assign {sa, ea, fa} = s_axis_a_tdata;
  assign {sb, eb, fb} = s_axis_b_tdata;
  assign a_sub  = (ea == '0);
  assign b_sub  = (eb == '0);
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = a_sub & ~(|fa);
  assign b_zero = b_sub & ~(|fb);
  assign ma     = {~a_sub, fa};
  assign mb     = {~b_sub, fb};

  // Subnormals carry exponent 1 with hidden bit 0.
  assign exp_sum_c = EW'(a_sub ? EXP'(1) : ea) + EW'(b_sub ? EXP'(1) : eb) - EW'(BIAS);

  always_comb begin
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) cls_c = CLS_NAN;
    else if (a_inf | b_inf)                                 cls_c = CLS_INF;
    else if (a_zero | b_zero)                               cls_c = CLS_ZERO;
    else                                                    cls_c = CLS_FIN;
  end

  fp_lzc #(.WIDTH(MW)) u_lzc_a (.value(ma), .count(lza));
  fp_lzc #(.WIDTH(MW)) u_lzc_b (.value(mb), .count(lzb));

  fp_class_e     cls1;
  logic          sign1, rnd1;
  logic [EW-1:0] exp1;
  logic [PW-1:0] prod1;
  logic [LW:0]   lz1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v1    <= 1'b0;
      cls1  <= CLS_FIN;
      sign1 <= 1'b0;
      rnd1  <= 1'b0;
      exp1  <= '0;
      prod1 <= '0;
      lz1   <= '0;
    end else if (en1) begin
      v1    <= accept;
      cls1  <= cls_c;
      sign1 <= sa ^ sb;
      rnd1  <= rnd_mode;
      exp1  <= exp_sum_c;
      prod1 <= PW'(ma) * PW'(mb);
      lz1   <= (LW+1)'(lza) + (LW+1)'(lzb);
    end
  end

  // ---------------- S2: normalize, denormalize tiny results ----------------
  logic [PW-1:0]   prod_sh, man_n, man_c;
  logic [EW-1:0]   exp_n, exp_c, rsh;
  logic [2*PW-1:0] wide;
  logic            sticky_c;

  always_comb begin
    prod_sh = prod1 << lz1;
    if (prod_sh[PW-1]) begin
      man_n = prod_sh;
      exp_n = exp1 - EW'(lz1) + EW'(1);
    end else begin
      man_n = prod_sh << 1;
      exp_n = exp1 - EW'(lz1);
    end
    // Shifts past the full significand only feed the sticky bit, so cap them.
    rsh = EW'(1) - exp_n;
    if (rsh > EW'(PW + 1)) rsh = EW'(PW + 1);
    wide = {man_n, {PW{1'b0}}} >> rsh;
    if (exp_n[EW-1] || exp_n == '0) begin
      man_c    = wide[2*PW-1:PW];
      sticky_c = |wide[PW-1:0];
      exp_c    = '0;
    end else begin
      man_c    = man_n;
      sticky_c = 1'b0;
      exp_c    = exp_n;
    end
  end

  fp_class_e     cls2;
  logic          sign2, rnd2, sticky2;
  logic [EW-1:0] exp2;
  logic [PW-1:0] man2;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v2      <= 1'b0;
      cls2    <= CLS_FIN;
      sign2   <= 1'b0;
      rnd2    <= 1'b0;
      sticky2 <= 1'b0;
      exp2    <= '0;
      man2    <= '0;
    end else if (en2) begin
      v2      <= v1;
      cls2    <= cls1;
      sign2   <= sign1;
      rnd2    <= rnd1;
      sticky2 <= sticky_c;
      exp2    <= exp_c;
      man2    <= man_c;
    end
  end

  // ---------------- S3: round, pack, flags ----------------
  logic [MW-1:0]     keep;
  logic              guard, sticky_all, inc;
  logic [MW:0]       mant_r;
  logic [EW-1:0]     exp_r;
  logic [W-1:0]      data_c;
  logic [FLAG_W-1:0] flag_c;

  always_comb begin
    keep       = man2[PW-1:FRA+1];
    guard      = man2[FRA];
    sticky_all = sticky2 | (|man2[FRA-1:0]);
    inc        = (rnd2 == RND_RNE) & guard & (sticky_all | keep[0]);
    mant_r     = {1'b0, keep} + (MW+1)'(inc);
    // A subnormal that rounds up into the hidden bit becomes the smallest normal.
    if (exp2 == '0) exp_r = EW'(mant_r[FRA]);
    else            exp_r = exp2 + EW'(mant_r[MW]);
    data_c = '0;
    flag_c = '0;
    case (cls2)
      CLS_NAN: begin
        data_c           = QNAN;
        flag_c[FLAG_NAN] = 1'b1;
      end
      CLS_INF: begin
        data_c           = {sign2, {EXP{1'b1}}, {FRA{1'b0}}};
        flag_c[FLAG_INF] = 1'b1;
      end
      CLS_ZERO: begin
        data_c            = {sign2, {(W-1){1'b0}}};
        flag_c[FLAG_ZERO] = 1'b1;
      end
      default: begin
        if (exp_r >= EW'(EMAX)) begin
          flag_c[FLAG_OVF]     = 1'b1;
          flag_c[FLAG_INEXACT] = 1'b1;
          if (rnd2 == RND_RTZ) begin
            data_c = {sign2, MAXF};
          end else begin
            data_c           = {sign2, {EXP{1'b1}}, {FRA{1'b0}}};
            flag_c[FLAG_INF] = 1'b1;
          end
        end else begin
          data_c               = {sign2, exp_r[EXP-1:0], mant_r[FRA-1:0]};
          flag_c[FLAG_INEXACT] = guard | sticky_all;
          flag_c[FLAG_ZERO]    = (exp_r == '0) && (mant_r[FRA-1:0] == '0);
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v3                  <= 1'b0;
      m_axis_result_tdata <= '0;
      flag                <= '0;
    end else if (en3) begin
      v3                  <= v2;
      m_axis_result_tdata <= data_c;
      flag                <= flag_c;
    end
  end

endmodule
